// File: rtl/bayer_mosaicing.sv
// RGB to Bayer RAW mosaicing for AXI4-Stream video.
// The colour is picked by pixel parity and CFA pattern, then passes through an output register backed by a skid register.
module bayer_mosaicing #(
    parameter int RAW_PX_WIDTH      = 10,
    parameter int RGB_TDATA_WIDTH   = 32,
    parameter int RGB_TDATA_WIDTH_B = 4,
    parameter int RAW_TDATA_WIDTH   = 16,
    parameter int RAW_TDATA_WIDTH_B = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [1:0]                   pattern_i,
    input  logic [RGB_TDATA_WIDTH-1:0]   rgb_tdata_i,
    input  logic [RGB_TDATA_WIDTH_B-1:0] rgb_tstrb_i,
    input  logic [RGB_TDATA_WIDTH_B-1:0] rgb_tkeep_i,
    input  logic                         rgb_tvalid_i,
    input  logic                         rgb_tlast_i,
    input  logic                         rgb_tuser_i,
    input  logic                         rgb_tid_i,
    input  logic                         rgb_tdest_i,
    output logic                         rgb_tready_o,
    output logic [RAW_TDATA_WIDTH-1:0]   raw_tdata_o,
    output logic [RAW_TDATA_WIDTH_B-1:0] raw_tstrb_o,
    output logic [RAW_TDATA_WIDTH_B-1:0] raw_tkeep_o,
    output logic                         raw_tvalid_o,
    output logic                         raw_tlast_o,
    output logic                         raw_tuser_o,
    output logic                         raw_tid_o,
    output logic                         raw_tdest_o,
    input  logic                         raw_tready_i
);
    localparam int P = RAW_PX_WIDTH;

    typedef struct packed {
        logic [RAW_TDATA_WIDTH-1:0] data;
        logic                       last;
        logic                       user;
        logic                       id;
        logic                       dest;
    } beat_t;

    beat_t      out_q, out_d, skid_q, skid_d, in_beat;
    logic       out_valid_q, out_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic       ready_q, ready_d;
    logic       col_par_q, col_par_d, row_par_q, row_par_d;
    logic [1:0] act_pattern_q, act_pattern_d;

    logic       accept, out_stall;
    logic       cur_col, cur_row;
    logic [1:0] cur_pat, sel;
    logic [P-1:0] pix;

    logic unused_inputs;
    assign unused_inputs = ^{rgb_tstrb_i, rgb_tkeep_i, rgb_tdata_i};

    assign accept    = rgb_tvalid_i & ready_q;
    assign out_stall = out_valid_q & ~raw_tready_i;

    // A start-of-frame beat is pixel (0,0) and already uses the freshly sampled pattern.
    always_comb begin
        cur_col = rgb_tuser_i ? 1'b0 : col_par_q;
        cur_row = rgb_tuser_i ? 1'b0 : row_par_q;
        cur_pat = rgb_tuser_i ? pattern_i : act_pattern_q;
        // XOR with the pattern maps every CFA onto RGGB: 00 is red, 11 is blue.
        sel = {cur_row, cur_col} ^ cur_pat;
        case (sel)
            2'b00:   pix = rgb_tdata_i[3*P-1:2*P];
            2'b11:   pix = rgb_tdata_i[P-1:0];
            default: pix = rgb_tdata_i[2*P-1:P];
        endcase
        in_beat           = '0;
        in_beat.data[P-1:0] = pix;
        in_beat.last      = rgb_tlast_i;
        in_beat.user      = rgb_tuser_i;
        in_beat.id        = rgb_tid_i;
        in_beat.dest      = rgb_tdest_i;
    end

    always_comb begin
        col_par_d     = col_par_q;
        row_par_d     = row_par_q;
        act_pattern_d = act_pattern_q;
        if (accept) begin
            act_pattern_d = cur_pat;
            if (rgb_tlast_i) begin
                col_par_d = 1'b0;
                row_par_d = ~cur_row;
            end else begin
                col_par_d = ~cur_col;
                row_par_d = cur_row;
            end
        end
    end

    // The skid register only fills while the output is stalled; it always drains first.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!out_stall) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_d = in_beat;
                end
            end
        end else if (accept) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
        ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q         <= '0;
            out_valid_q   <= 1'b0;
            skid_q        <= '0;
            skid_valid_q  <= 1'b0;
            ready_q       <= 1'b0;
            col_par_q     <= 1'b0;
            row_par_q     <= 1'b0;
            act_pattern_q <= 2'd0;
        end else begin
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            skid_q        <= skid_d;
            skid_valid_q  <= skid_valid_d;
            ready_q       <= ready_d;
            col_par_q     <= col_par_d;
            row_par_q     <= row_par_d;
            act_pattern_q <= act_pattern_d;
        end
    end

    assign rgb_tready_o = ready_q;
    assign raw_tvalid_o = out_valid_q;
    assign raw_tdata_o  = out_q.data;
    assign raw_tlast_o  = out_q.last;
    assign raw_tuser_o  = out_q.user;
    assign raw_tid_o    = out_q.id;
    assign raw_tdest_o  = out_q.dest;

    generate
        for (genvar gi = 0; gi < RAW_TDATA_WIDTH_B; gi++) begin : g_strb
            assign raw_tstrb_o[gi] = out_valid_q;
            assign raw_tkeep_o[gi] = out_valid_q;
        end
    endgenerate
endmodule

// File: tb/tb_bayer_mosaicing.sv
// Directed and randomized-handshake bench for bayer_mosaicing.
module tb_bayer_mosaicing;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  pattern_i = 2'd0;
    logic [31:0] rgb_tdata_i = '0;
    logic [3:0]  rgb_tstrb_i = 4'hF;
    logic [3:0]  rgb_tkeep_i = 4'hF;
    logic        rgb_tvalid_i = 1'b0;
    logic        rgb_tlast_i = 1'b0;
    logic        rgb_tuser_i = 1'b0;
    logic        rgb_tid_i = 1'b0;
    logic        rgb_tdest_i = 1'b0;
    logic        rgb_tready_o;
    logic [15:0] raw_tdata_o;
    logic [1:0]  raw_tstrb_o, raw_tkeep_o;
    logic        raw_tvalid_o, raw_tlast_o, raw_tuser_o, raw_tid_o, raw_tdest_o;
    logic        raw_tready_i = 1'b1;

    int total = 0;
    int fails = 0;
    logic [9:0] exp_tab [0:3][0:7];
    string pats [0:3];

    bayer_mosaicing dut (
        .clk_i(clk_i), .rst_i(rst_i), .pattern_i(pattern_i),
        .rgb_tdata_i(rgb_tdata_i), .rgb_tstrb_i(rgb_tstrb_i), .rgb_tkeep_i(rgb_tkeep_i),
        .rgb_tvalid_i(rgb_tvalid_i), .rgb_tlast_i(rgb_tlast_i), .rgb_tuser_i(rgb_tuser_i),
        .rgb_tid_i(rgb_tid_i), .rgb_tdest_i(rgb_tdest_i), .rgb_tready_o(rgb_tready_o),
        .raw_tdata_o(raw_tdata_o), .raw_tstrb_o(raw_tstrb_o), .raw_tkeep_o(raw_tkeep_o),
        .raw_tvalid_o(raw_tvalid_o), .raw_tlast_o(raw_tlast_o), .raw_tuser_o(raw_tuser_o),
        .raw_tid_o(raw_tid_o), .raw_tdest_o(raw_tdest_o), .raw_tready_i(raw_tready_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] pack(input int i);
        logic [9:0] r, g, b;
        r = 10'(32'h100 + i);
        g = 10'(32'h200 + i);
        b = 10'(32'h300 + i);
        return {2'b00, r, g, b};
    endfunction

    function automatic logic [9:0] pick(input int pat, input int r, input int c,
                                        input logic [9:0] rr, input logic [9:0] gg, input logic [9:0] bb);
        string s;
        byte   ch;
        s  = pats[pat];
        ch = s.getc((r % 2) * 2 + (c % 2));
        if (ch == "R") return rr;
        if (ch == "B") return bb;
        return gg;
    endfunction

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        total++;
        if ({raw_tvalid_o, raw_tdata_o, raw_tlast_o, raw_tuser_o, raw_tid_o, raw_tdest_o} !== 21'd0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b data=%h expected all zero", raw_tvalid_o, raw_tdata_o);
        end
        total++;
        if ({rgb_tready_o, raw_tstrb_o, raw_tkeep_o} !== 5'd0) begin
            fails++;
            $display("FAIL reset_ready: got tready=%b strb=%b keep=%b expected 0", rgb_tready_o, raw_tstrb_o, raw_tkeep_o);
        end
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        total++;
        if (rgb_tready_o !== 1'b1 || raw_tvalid_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: got tready=%b valid=%b expected tready=1 valid=0", rgb_tready_o, raw_tvalid_o);
        end
        $display("reset: released, tready=%b", rgb_tready_o);
    endtask

    // 4x2 frame; pattern_i switches from pat_a to pat_b after pixel 1.
    task automatic test_frame(input int pat_a, input int pat_b, input int sel);
        logic [24:0] got, want;
        for (int i = 0; i < 8; i++) begin
            pattern_i    = (i < 2) ? 2'(pat_a) : 2'(pat_b);
            rgb_tdata_i  = pack(i);
            rgb_tvalid_i = 1'b1;
            rgb_tuser_i  = (i == 0);
            rgb_tlast_i  = (i == 3 || i == 7);
            rgb_tid_i    = i[0];
            rgb_tdest_i  = i[1];
            @(posedge clk_i); #1;
            got  = {raw_tvalid_o, raw_tlast_o, raw_tuser_o, raw_tid_o, raw_tdest_o, raw_tstrb_o, raw_tkeep_o, raw_tdata_o};
            want = {1'b1, rgb_tlast_i, rgb_tuser_i, rgb_tid_i, rgb_tdest_i, 4'hF, 6'd0, exp_tab[sel][i]};
            total++;
            if (got !== want) begin
                fails++;
                $display("FAIL frame_tab%0d_px%0d: got %h expected %h", sel, i, got, want);
            end
            $display("frame tab%0d px%0d: raw=%h", sel, i, raw_tdata_o);
        end
        rgb_tvalid_i = 1'b0;
        rgb_tuser_i  = 1'b0;
        rgb_tlast_i  = 1'b0;
        @(posedge clk_i); #1;
        total++;
        if (raw_tvalid_o !== 1'b0) begin
            fails++;
            $display("FAIL frame_tab%0d_idle: got valid=%b expected 0", sel, raw_tvalid_o);
        end
    endtask

    task automatic test_resync();
        logic [9:0] want [0:6];
        want = '{10'h100, 10'h201, 10'h102, 10'h203, 10'h204, 10'h105, 10'h206};
        pattern_i = 2'd0;
        for (int i = 0; i < 7; i++) begin
            rgb_tdata_i  = pack(i);
            rgb_tvalid_i = 1'b1;
            rgb_tuser_i  = (i == 0 || i == 5);
            rgb_tlast_i  = (i == 3);
            rgb_tid_i    = 1'b0;
            rgb_tdest_i  = 1'b0;
            @(posedge clk_i); #1;
            total++;
            if ({raw_tvalid_o, raw_tuser_o, raw_tdata_o} !== {1'b1, rgb_tuser_i, 6'd0, want[i]}) begin
                fails++;
                $display("FAIL resync_px%0d: got valid=%b user=%b data=%h expected 1 %b %h",
                         i, raw_tvalid_o, raw_tuser_o, raw_tdata_o, rgb_tuser_i, want[i]);
            end
            $display("resync px%0d: raw=%h user=%b", i, raw_tdata_o, raw_tuser_o);
        end
        rgb_tvalid_i = 1'b0;
        rgb_tuser_i  = 1'b0;
        rgb_tlast_i  = 1'b0;
        @(posedge clk_i); #1;
    endtask

    // Three 8x4 frames (patterns 1..3) with random valid and ready.
    task automatic test_random();
        int gen = 0;
        int rx = 0;
        int cyc = 0;
        int f = 0, r = 0, c = 0;
        logic pending = 1'b0;
        logic stalled = 1'b0;
        logic [24:0] got, snap, want;
        logic [24:0] expq [$];
        logic [9:0] cr, cg, cb;
        rgb_tvalid_i = 1'b0;
        snap = '0;
        while (rx < 96 && cyc < 4000) begin
            got = {raw_tvalid_o, raw_tlast_o, raw_tuser_o, raw_tid_o, raw_tdest_o, raw_tstrb_o, raw_tkeep_o, raw_tdata_o};
            if (stalled) begin
                total++;
                if (got !== snap) begin
                    fails++;
                    $display("FAIL stall_hold_cyc%0d: got %h expected %h", cyc, got, snap);
                end
            end
            total++;
            if (rgb_tready_o !== 1'(expq.size() < 2)) begin
                fails++;
                $display("FAIL ready_vs_fill_cyc%0d: got tready=%b expected %b (held %0d)",
                         cyc, rgb_tready_o, expq.size() < 2, expq.size());
            end
            if (!pending && gen < 96 && $urandom_range(0, 1) == 1) begin
                f  = gen / 32;
                r  = (gen % 32) / 8;
                c  = gen % 8;
                cr = 10'($urandom_range(0, 1023));
                cg = 10'($urandom_range(0, 1023));
                cb = 10'($urandom_range(0, 1023));
                pattern_i    = 2'(f + 1);
                rgb_tdata_i  = {2'b00, cr, cg, cb};
                rgb_tuser_i  = (r == 0 && c == 0);
                rgb_tlast_i  = (c == 7);
                rgb_tid_i    = 1'($urandom_range(0, 1));
                rgb_tdest_i  = 1'($urandom_range(0, 1));
                rgb_tvalid_i = 1'b1;
                pending = 1'b1;
            end else if (!pending) begin
                rgb_tvalid_i = 1'b0;
            end
            raw_tready_i = 1'($urandom_range(0, 1));
            if (raw_tvalid_o && raw_tready_i) begin
                if (expq.size() > 0) want = expq.pop_front();
                else want = 'x;
                total++;
                if (got !== want) begin
                    fails++;
                    $display("FAIL random_beat%0d: got %h expected %h", rx, got, want);
                end
                $display("random beat%0d: raw=%h", rx, raw_tdata_o);
                rx++;
            end
            if (rgb_tvalid_i && rgb_tready_o) begin
                expq.push_back({1'b1, rgb_tlast_i, rgb_tuser_i, rgb_tid_i, rgb_tdest_i, 4'hF, 6'd0,
                                pick(f + 1, r, c, cr, cg, cb)});
                pending = 1'b0;
                gen++;
            end
            stalled = raw_tvalid_o && !raw_tready_i;
            snap = got;
            @(posedge clk_i); #1;
            cyc++;
        end
        rgb_tvalid_i = 1'b0;
        rgb_tuser_i  = 1'b0;
        rgb_tlast_i  = 1'b0;
        total++;
        if (rx != 96) begin
            fails++;
            $display("FAIL random_complete: got %0d beats expected 96", rx);
        end
    endtask

    task automatic test_reset_skid();
        raw_tready_i = 1'b0;
        pattern_i    = 2'd0;
        for (int i = 0; i < 2; i++) begin
            rgb_tdata_i  = pack(i);
            rgb_tvalid_i = 1'b1;
            rgb_tuser_i  = (i == 0);
            rgb_tlast_i  = 1'b0;
            @(posedge clk_i); #1;
        end
        rgb_tvalid_i = 1'b0;
        rgb_tuser_i  = 1'b0;
        total++;
        if ({rgb_tready_o, raw_tvalid_o, raw_tdata_o} !== {1'b0, 1'b1, 16'h0100}) begin
            fails++;
            $display("FAIL skid_full: got tready=%b valid=%b data=%h expected 0 1 0100",
                     rgb_tready_o, raw_tvalid_o, raw_tdata_o);
        end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        total++;
        if ({raw_tvalid_o, rgb_tready_o} !== 2'b00) begin
            fails++;
            $display("FAIL midreset_cycle: got valid=%b tready=%b expected 0 0", raw_tvalid_o, rgb_tready_o);
        end
        @(posedge clk_i); #1;
        total++;
        if ({raw_tvalid_o, rgb_tready_o} !== 2'b01) begin
            fails++;
            $display("FAIL midreset_release: got valid=%b tready=%b expected 0 1", raw_tvalid_o, rgb_tready_o);
        end
        $display("mid-line reset: tready=%b valid=%b", rgb_tready_o, raw_tvalid_o);
        raw_tready_i = 1'b1;
        test_frame(0, 0, 0);
    endtask

    initial begin
        exp_tab = '{'{10'h100, 10'h201, 10'h102, 10'h203, 10'h204, 10'h305, 10'h206, 10'h307},
                    '{10'h200, 10'h101, 10'h202, 10'h103, 10'h304, 10'h205, 10'h306, 10'h207},
                    '{10'h200, 10'h301, 10'h202, 10'h303, 10'h104, 10'h205, 10'h106, 10'h207},
                    '{10'h300, 10'h201, 10'h302, 10'h203, 10'h204, 10'h105, 10'h206, 10'h107}};
        pats = '{"RGGB", "GRBG", "GBRG", "BGGR"};
        test_reset();
        test_frame(0, 0, 0);
        test_frame(1, 1, 1);
        test_frame(2, 2, 2);
        test_frame(3, 3, 3);
        test_frame(0, 3, 0);
        test_frame(3, 3, 3);
        test_resync();
        test_random();
        test_reset_skid();
        $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
        $finish;
    end
endmodule
